// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   requester_t : identity of the two requesters
package memory_arbiter_pkg;

  localparam int unsigned MEM_ADDR_WIDTH  = 17;
  localparam int unsigned DEFAULT_TIMEOUT = 15;
  localparam int unsigned DATA_WIDTH      = 8;
  localparam int unsigned WATCHDOG_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } arb_state_t;

  typedef enum logic {
    REQ_HOST,
    REQ_BLIT
  } requester_t;

endpackage

// File: rtl/arbiter_watchdog.sv
// Transaction watchdog: counts BUSY cycles and flags a hung transaction.
//   clock, reset : clock, async active-low reset
//   clear        : zero the counter (transaction accepted)
//   enable       : count this cycle (transaction in flight)
//   expired      : this edge is the TIMEOUT_CYCLES-th BUSY edge
module arbiter_watchdog
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CountWidth = WATCHDOG_WIDTH + 1;

  logic [WATCHDOG_WIDTH-1:0] count;
  logic [CountWidth-1:0]     countNext;

  // One bit of headroom so the compare never sees a wrapped value.
  assign countNext = {1'b0, count} + CountWidth'(1);

  // Compare the post-increment value so the abort lands exactly on the
  // TIMEOUT_CYCLES-th edge after acceptance.
  assign expired = enable && (countNext >= CountWidth'(TIMEOUT_CYCLES));

  // Cycle counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= countNext[WATCHDOG_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing the memory manager CPU port between the host
// bus interface and the blitter, with a watchdog that turns hung
// transactions into error responses.
//   host*/blit* Req  : valid/ready request (ready is combinational)
//   host*/blit* Resp : one-cycle registered response strobe, data, error
//   memory*          : registered level requests, address, write data;
//                      read data and completion pulses from the manager
//   busy             : arbiter is not IDLE
module memory_port_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = MEM_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hostReqValid,
  input  logic                  hostReqWrite,
  input  logic [ADDR_WIDTH-1:0] hostReqAddress,
  input  logic [DATA_WIDTH-1:0] hostReqWriteData,
  output logic                  hostReqReady,
  output logic                  hostRespValid,
  output logic [DATA_WIDTH-1:0] hostRespData,
  output logic                  hostRespError,
  input  logic                  blitReqValid,
  input  logic                  blitReqWrite,
  input  logic [ADDR_WIDTH-1:0] blitReqAddress,
  input  logic [DATA_WIDTH-1:0] blitReqWriteData,
  output logic                  blitReqReady,
  output logic                  blitRespValid,
  output logic [DATA_WIDTH-1:0] blitRespData,
  output logic                  blitRespError,
  output logic [ADDR_WIDTH-1:0] memoryAddress,
  output logic                  memoryReadRequest,
  output logic                  memoryWriteRequest,
  output logic [DATA_WIDTH-1:0] memoryWriteData,
  input  logic [DATA_WIDTH-1:0] memoryReadData,
  input  logic                  memoryReadComplete,
  input  logic                  memoryWriteComplete,
  output logic                  busy
);

  arb_state_t state, stateNext;
  requester_t owner, lastServed;

  logic                  grantHost, grantBlit, accept;
  logic                  completeHit, respDone, respErrorNext;
  logic [DATA_WIDTH-1:0] respDataNext;
  logic                  watchdogClear, watchdogEnable, watchdogExpired;

  arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (watchdogClear),
    .enable (watchdogEnable),
    .expired(watchdogExpired)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state, grant and completion decode.
  always_comb begin
    stateNext      = state;
    grantHost      = 1'b0;
    grantBlit      = 1'b0;
    accept         = 1'b0;
    completeHit    = 1'b0;
    respDone       = 1'b0;
    respErrorNext  = 1'b0;
    respDataNext   = '0;
    watchdogClear  = 1'b0;
    watchdogEnable = 1'b0;
    case (state)
      IDLE: begin
        // Under contention, the requester not served last wins.
        if (hostReqValid && (!blitReqValid || lastServed == REQ_BLIT)) grantHost = 1'b1;
        else if (blitReqValid)                                          grantBlit = 1'b1;
        accept = grantHost || grantBlit;
        if (accept) begin
          watchdogClear = 1'b1;
          stateNext     = BUSY;
        end
      end
      BUSY: begin
        watchdogEnable = 1'b1;
        // Only the completion matching the outstanding request counts.
        completeHit    = memoryWriteRequest ? memoryWriteComplete : memoryReadComplete;
        respDone       = completeHit || watchdogExpired;
        respErrorNext  = !completeHit;
        if (completeHit && memoryReadRequest) respDataNext = memoryReadData;
        if (respDone) stateNext = RESPOND;
      end
      RESPOND: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign hostReqReady = grantHost;
  assign blitReqReady = grantBlit;

  // Datapath, memory-side requests and response strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner              <= REQ_HOST;
      lastServed         <= REQ_BLIT;
      memoryAddress      <= '0;
      memoryWriteData    <= '0;
      memoryReadRequest  <= 1'b0;
      memoryWriteRequest <= 1'b0;
      hostRespValid      <= 1'b0;
      hostRespData       <= '0;
      hostRespError      <= 1'b0;
      blitRespValid      <= 1'b0;
      blitRespData       <= '0;
      blitRespError      <= 1'b0;
      busy               <= 1'b0;
    end else begin
      busy          <= (stateNext != IDLE);
      hostRespValid <= 1'b0;
      hostRespData  <= '0;
      hostRespError <= 1'b0;
      blitRespValid <= 1'b0;
      blitRespData  <= '0;
      blitRespError <= 1'b0;
      if (accept) begin
        owner              <= grantHost ? REQ_HOST : REQ_BLIT;
        memoryAddress      <= grantHost ? hostReqAddress : blitReqAddress;
        memoryWriteData    <= grantHost ? hostReqWriteData : blitReqWriteData;
        memoryWriteRequest <= grantHost ? hostReqWrite : blitReqWrite;
        memoryReadRequest  <= grantHost ? !hostReqWrite : !blitReqWrite;
      end
      if (respDone) begin
        // Drop the request on the completion edge so it stays low for
        // at least two cycles before the next acceptance.
        memoryReadRequest  <= 1'b0;
        memoryWriteRequest <= 1'b0;
        if (owner == REQ_HOST) begin
          hostRespValid <= 1'b1;
          hostRespData  <= respDataNext;
          hostRespError <= respErrorNext;
        end else begin
          blitRespValid <= 1'b1;
          blitRespData  <= respDataNext;
          blitRespError <= respErrorNext;
        end
      end
      if (state == RESPOND) lastServed <= owner;
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed self-checking bench for memory_port_arbiter (TIMEOUT_CYCLES = 8).
module tb_memory_port_arbiter;

  logic        clock;
  logic        reset;
  logic        hostReqValid, hostReqWrite, hostReqReady;
  logic [16:0] hostReqAddress;
  logic [7:0]  hostReqWriteData;
  logic        hostRespValid, hostRespError;
  logic [7:0]  hostRespData;
  logic        blitReqValid, blitReqWrite, blitReqReady;
  logic [16:0] blitReqAddress;
  logic [7:0]  blitReqWriteData;
  logic        blitRespValid, blitRespError;
  logic [7:0]  blitRespData;
  logic [16:0] memoryAddress;
  logic        memoryReadRequest, memoryWriteRequest;
  logic [7:0]  memoryWriteData, memoryReadData;
  logic        memoryReadComplete, memoryWriteComplete;
  logic        busy;

  int testsRun    = 0;
  int testsFailed = 0;

  memory_port_arbiter #(
    .ADDR_WIDTH    (17),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .hostReqValid       (hostReqValid),
    .hostReqWrite       (hostReqWrite),
    .hostReqAddress     (hostReqAddress),
    .hostReqWriteData   (hostReqWriteData),
    .hostReqReady       (hostReqReady),
    .hostRespValid      (hostRespValid),
    .hostRespData       (hostRespData),
    .hostRespError      (hostRespError),
    .blitReqValid       (blitReqValid),
    .blitReqWrite       (blitReqWrite),
    .blitReqAddress     (blitReqAddress),
    .blitReqWriteData   (blitReqWriteData),
    .blitReqReady       (blitReqReady),
    .blitRespValid      (blitRespValid),
    .blitRespData       (blitRespData),
    .blitRespError      (blitRespError),
    .memoryAddress      (memoryAddress),
    .memoryReadRequest  (memoryReadRequest),
    .memoryWriteRequest (memoryWriteRequest),
    .memoryWriteData    (memoryWriteData),
    .memoryReadData     (memoryReadData),
    .memoryReadComplete (memoryReadComplete),
    .memoryWriteComplete(memoryWriteComplete),
    .busy               (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b0;
    hostReqValid = 1'b0; hostReqWrite = 1'b0; hostReqAddress = '0; hostReqWriteData = '0;
    blitReqValid = 1'b0; blitReqWrite = 1'b0; blitReqAddress = '0; blitReqWriteData = '0;
    memoryReadData = '0; memoryReadComplete = 1'b0; memoryWriteComplete = 1'b0;
    #1;
    check("rst_readReq", 32'(memoryReadRequest), 32'd0);
    check("rst_writeReq", 32'(memoryWriteRequest), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hostRespValid", 32'(hostRespValid), 32'd0);
    check("rst_blitRespValid", 32'(blitRespValid), 32'd0);
    check("rst_address", 32'(memoryAddress), 32'd0);
    tick(); tick();
    reset = 1'b1;

    // Host read of 0x00123 returning 0xA5.
    hostReqValid = 1'b1; hostReqWrite = 1'b0; hostReqAddress = 17'h00123;
    #1;
    check("t1_hostReady", 32'(hostReqReady), 32'd1);
    check("t1_blitReady", 32'(blitReqReady), 32'd0);
    tick();
    hostReqValid = 1'b0;
    check("t1_readReq", 32'(memoryReadRequest), 32'd1);
    check("t1_writeReq", 32'(memoryWriteRequest), 32'd0);
    check("t1_address", 32'(memoryAddress), 32'h00123);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_hostReadyBusy", 32'(hostReqReady), 32'd0);
    tick(); tick(); tick();
    check("t1_held", 32'(memoryReadRequest), 32'd1);
    check("t1_noEarlyResp", 32'(hostRespValid), 32'd0);
    memoryReadData = 8'hA5; memoryReadComplete = 1'b1;
    tick();
    memoryReadComplete = 1'b0; memoryReadData = 8'h00;
    check("t1_reqDrop", 32'(memoryReadRequest), 32'd0);
    check("t1_respValid", 32'(hostRespValid), 32'd1);
    check("t1_respData", 32'(hostRespData), 32'hA5);
    check("t1_respError", 32'(hostRespError), 32'd0);
    check("t1_blitRespValid", 32'(blitRespValid), 32'd0);
    check("t1_blitRespData", 32'(blitRespData), 32'd0);
    tick();
    check("t1_pulseOnce", 32'(hostRespValid), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // Contention right after reset: host first, then blit back-to-back writes.
    reset = 1'b0; #3; reset = 1'b1;
    hostReqValid = 1'b1; hostReqWrite = 1'b0; hostReqAddress = 17'h00010;
    blitReqValid = 1'b1; blitReqWrite = 1'b1; blitReqAddress = 17'h1FFFF; blitReqWriteData = 8'h3C;
    #1;
    check("t2_hostReady", 32'(hostReqReady), 32'd1);
    check("t2_blitReady", 32'(blitReqReady), 32'd0);
    tick();
    hostReqValid = 1'b0;
    check("t2_readReq", 32'(memoryReadRequest), 32'd1);
    check("t2_address", 32'(memoryAddress), 32'h00010);
    check("t2_blitReadyBusy", 32'(blitReqReady), 32'd0);
    memoryReadData = 8'h5A; memoryReadComplete = 1'b1;
    tick();
    memoryReadComplete = 1'b0; memoryReadData = 8'h00;
    check("t2_lowCycle1", 32'(memoryReadRequest), 32'd0);
    check("t2_hostRespValid", 32'(hostRespValid), 32'd1);
    check("t2_hostRespData", 32'(hostRespData), 32'h5A);
    check("t2_blitReadyRespond", 32'(blitReqReady), 32'd0);
    tick();
    check("t2_lowCycle2R", 32'(memoryReadRequest), 32'd0);
    check("t2_lowCycle2W", 32'(memoryWriteRequest), 32'd0);
    check("t2_blitGranted", 32'(blitReqReady), 32'd1);
    check("t2_hostNotReady", 32'(hostReqReady), 32'd0);
    tick();
    check("t3_writeReq", 32'(memoryWriteRequest), 32'd1);
    check("t3_readReq", 32'(memoryReadRequest), 32'd0);
    check("t3_writeData", 32'(memoryWriteData), 32'h3C);
    check("t3_address", 32'(memoryAddress), 32'h1FFFF);
    tick();
    memoryWriteComplete = 1'b1;
    tick();
    memoryWriteComplete = 1'b0;
    check("t3_blitRespValid", 32'(blitRespValid), 32'd1);
    check("t3_blitRespData", 32'(blitRespData), 32'd0);
    check("t3_blitRespError", 32'(blitRespError), 32'd0);
    check("t3_hostRespValid", 32'(hostRespValid), 32'd0);
    check("t3_writeDrop", 32'(memoryWriteRequest), 32'd0);
    tick();
    check("t3_blitAgain", 32'(blitReqReady), 32'd1);
    tick();
    blitReqValid = 1'b0;
    check("t3_writeReq2", 32'(memoryWriteRequest), 32'd1);
    check("t3_address2", 32'(memoryAddress), 32'h1FFFF);
    check("t3_writeData2", 32'(memoryWriteData), 32'h3C);
    memoryWriteComplete = 1'b1;
    tick();
    memoryWriteComplete = 1'b0;
    check("t3_blitRespValid2", 32'(blitRespValid), 32'd1);
    check("t3_blitRespData2", 32'(blitRespData), 32'd0);
    tick();
    check("t3_idle", 32'(busy), 32'd0);

    // Timeout: no completion, abort on edge 8 after acceptance.
    hostReqValid = 1'b1; hostReqWrite = 1'b0; hostReqAddress = 17'h00055;
    #1;
    check("t4_hostReady", 32'(hostReqReady), 32'd1);
    tick();
    hostReqValid = 1'b0; memoryReadData = 8'hFF;
    repeat (7) tick();
    check("t4_heldEdge7", 32'(memoryReadRequest), 32'd1);
    check("t4_noRespEdge7", 32'(hostRespValid), 32'd0);
    tick();
    check("t4_dropEdge8", 32'(memoryReadRequest), 32'd0);
    check("t4_respValid", 32'(hostRespValid), 32'd1);
    check("t4_respError", 32'(hostRespError), 32'd1);
    check("t4_respData", 32'(hostRespData), 32'd0);
    tick();
    memoryReadData = 8'h00;
    check("t4_respOnce", 32'(hostRespValid), 32'd0);
    check("t4_idle", 32'(busy), 32'd0);
    hostReqValid = 1'b1; hostReqWrite = 1'b1; hostReqAddress = 17'h00077; hostReqWriteData = 8'h99;
    tick();
    hostReqValid = 1'b0;
    check("t4_nextWriteReq", 32'(memoryWriteRequest), 32'd1);
    check("t4_nextWriteData", 32'(memoryWriteData), 32'h99);
    check("t4_nextAddress", 32'(memoryAddress), 32'h00077);
    memoryWriteComplete = 1'b1;
    tick();
    memoryWriteComplete = 1'b0;
    check("t4_nextRespValid", 32'(hostRespValid), 32'd1);
    check("t4_nextRespError", 32'(hostRespError), 32'd0);
    check("t4_nextRespData", 32'(hostRespData), 32'd0);
    tick();

    // Completion and timeout on the same edge: completion wins.
    hostReqValid = 1'b1; hostReqWrite = 1'b0; hostReqAddress = 17'h00200;
    tick();
    hostReqValid = 1'b0;
    repeat (7) tick();
    memoryReadData = 8'h81; memoryReadComplete = 1'b1;
    tick();
    memoryReadComplete = 1'b0; memoryReadData = 8'h00;
    check("tie_respValid", 32'(hostRespValid), 32'd1);
    check("tie_respError", 32'(hostRespError), 32'd0);
    check("tie_respData", 32'(hostRespData), 32'h81);
    tick();

    // Stray completions: readComplete in IDLE, writeComplete during a read.
    memoryReadComplete = 1'b1;
    tick();
    memoryReadComplete = 1'b0;
    check("t5_idleStayIdle", 32'(busy), 32'd0);
    check("t5_idleNoHostResp", 32'(hostRespValid), 32'd0);
    check("t5_idleNoBlitResp", 32'(blitRespValid), 32'd0);
    hostReqValid = 1'b1; hostReqWrite = 1'b0; hostReqAddress = 17'h0ABCD;
    tick();
    hostReqValid = 1'b0;
    tick();
    memoryWriteComplete = 1'b1;
    tick();
    memoryWriteComplete = 1'b0;
    check("t5_strayHeld", 32'(memoryReadRequest), 32'd1);
    check("t5_strayNoResp", 32'(hostRespValid), 32'd0);
    check("t5_strayBusy", 32'(busy), 32'd1);
    memoryReadData = 8'h3E; memoryReadComplete = 1'b1;
    tick();
    memoryReadComplete = 1'b0; memoryReadData = 8'h00;
    check("t5_respValid", 32'(hostRespValid), 32'd1);
    check("t5_respData", 32'(hostRespData), 32'h3E);
    check("t5_respError", 32'(hostRespError), 32'd0);
    tick();

    // Reset in BUSY: request drops at once, no response, host wins afterwards.
    hostReqValid = 1'b1; hostReqWrite = 1'b0; hostReqAddress = 17'h00999;
    tick();
    hostReqValid = 1'b0;
    tick();
    check("t6_busyReq", 32'(memoryReadRequest), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_asyncDrop", 32'(memoryReadRequest), 32'd0);
    check("t6_asyncBusy", 32'(busy), 32'd0);
    check("t6_asyncAddress", 32'(memoryAddress), 32'd0);
    tick(); tick();
    reset = 1'b1;
    check("t6_noResp", 32'(hostRespValid), 32'd0);
    tick();
    check("t6_noRespLater", 32'(hostRespValid), 32'd0);
    hostReqValid = 1'b1; hostReqWrite = 1'b0; hostReqAddress = 17'h00001;
    blitReqValid = 1'b1; blitReqWrite = 1'b0; blitReqAddress = 17'h00002;
    #1;
    check("t6_hostFirst", 32'(hostReqReady), 32'd1);
    check("t6_blitWaits", 32'(blitReqReady), 32'd0);
    tick();
    hostReqValid = 1'b0; blitReqValid = 1'b0;
    check("t6_address", 32'(memoryAddress), 32'h00001);
    check("t6_readReq", 32'(memoryReadRequest), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares the single CPU-side port of the memory manager (address, read/write request, write data, completion pulses) between two requesters: the host bus interface and the blitter. Each requester issues one transaction at a time through a valid/ready request and receives a one-cycle response. Grants are round-robin, and the request lines are held until the memory manager signals completion. A watchdog converts a hung transaction into an error response.

## Interface
- ADDR_WIDTH, 17: width of request and memory addresses.
- TIMEOUT_CYCLES, 15: maximum number of BUSY cycles before the transaction is aborted. Legal range is 8..255.
- clock  in  1: sole clock. All logic is on posedge.
- reset  in  1: asynchronous, active-low. Asserting it clears all state immediately.
- hostReqValid  in  1: host transaction pending. Inputs are held stable until accepted.
- hostReqWrite  in  1: 1 = write, 0 = read.
- hostReqAddress  in  ADDR_WIDTH: host address.
- hostReqWriteData  in  8: host write data.
- hostReqReady  out  1: combinational accept. The request is accepted on the edge where valid && ready.
- hostRespValid  out  1: one-cycle response strobe.
- hostRespData  out  8: read data, valid while hostRespValid is high. It is 0 for writes and for errors.
- hostRespError  out  1: the transaction timed out. Qualified by hostRespValid.
- blitReqValid, blitReqWrite, blitReqAddress, blitReqWriteData, blitReqReady, blitRespValid, blitRespData, blitRespError: same meanings as the host ports, for the blitter.
- memoryAddress  out  ADDR_WIDTH: registered. Held for the whole transaction.
- memoryReadRequest  out  1: registered level request.
- memoryWriteRequest  out  1: registered level request.
- memoryWriteData  out  8: registered. Held for the whole transaction.
- memoryReadData  in  8: read data from the memory manager.
- memoryReadComplete  in  1: one-cycle completion pulse for reads.
- memoryWriteComplete  in  1: one-cycle completion pulse for writes.
- busy  out  1: high whenever state ≠ IDLE.

## Operation
- **States:** IDLE, BUSY, RESPOND.
- **Arbitration in IDLE:**
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not `lastServed`.
  - Ready is driven only to the granted requester. Ready is 0 in BUSY and RESPOND.
- **IDLE → BUSY on acceptance:**
  - Latch the owner.
  - Latch address and write data into memoryAddress and memoryWriteData.
  - Assert memoryWriteRequest if the request is a write, otherwise memoryReadRequest.
  - Clear the watchdog counter.
- **BUSY:**
  - The request stays asserted. The counter increments each cycle.
  - On the edge where the matching complete pulse is sampled:
    - Clear the request.
    - For reads, capture memoryReadData.
    - Set error = 0 and go to RESPOND.
  - A complete pulse of the wrong type (e.g. write-complete during a read) is ignored.
  - When the counter reaches TIMEOUT_CYCLES without a match:
    - Clear the request.
    - Set data = 0 and error = 1, and go to RESPOND.
  - If a matching complete and the timeout occur on the same edge, the complete wins.
- **RESPOND:**
  - The owner's RespValid is 1 for exactly one cycle. The other requester's response outputs stay 0.
  - On the next edge: `lastServed` ← owner, state → IDLE.
- **Complete pulses in IDLE or RESPOND:** ignored.
- **Request low time:** the request drops on the completion edge, so memoryRead/WriteRequest is low for at least 2 cycles between transactions. This prevents the memory manager from re-issuing a transaction.
- **Reset values:**
  - State is IDLE and `lastServed` is blit, so the host wins the first contested grant.
  - All outputs are 0.
- **Reset mid-transaction:** requests drop asynchronously and the pending response is never delivered. After reset release, requesters must re-present their requests.
- **Arithmetic:** the counter is 8 bits and is compared with `>=` against TIMEOUT_CYCLES.

## Timing
- **Acceptance (edge 0):** request lines are high from cycle 1.
- **Completion sampled at edge N:** the request is low and RespValid is high during cycle N+1. The next acceptance can happen at edge N+2 at the earliest.
- **Nominal latency:** the memory manager round is 4 cycles, so acceptance to RespValid is 4–7 cycles.
- **Timeout:** the error RespValid appears TIMEOUT_CYCLES+1 cycles after acceptance.
- **Throughput:** at most one transaction per memory manager round. Requesters alternate under contention.

## Structure
- **Package `memory_arbiter_pkg`:**
  - `arb_state_t` enum: IDLE, BUSY, RESPOND.
  - `requester_t` enum: REQ_HOST, REQ_BLIT.
  - Constants MEM_ADDR_WIDTH = 17 and DEFAULT_TIMEOUT = 15.
- **Sub-module `arbiter_watchdog`:** the counter, with clear/enable inputs and an `expired` output.
- **Top level:** the FSM, grant logic and datapath registers stay in the top module.

## Test plan
- Host read of 0x00123 with the memory model returning 0xA5 → request is held until readComplete, then hostRespValid pulses once with data 0xA5 and error 0. The blit response stays 0.
- Host and blit valid together right after reset → host is granted first, then blit. The request lines are low for at least 2 cycles between the two transactions.
- Blit issues back-to-back writes of 0x3C to 0x1FFFF while the host is idle → every blit write is accepted. memoryWriteData = 0x3C, memoryAddress = 0x1FFFF, and each write gets one RespValid with data 0.
- TIMEOUT_CYCLES = 8 and the memory model never completes → request drops at edge 8. hostRespValid pulses with error 1 and data 0, then the next request proceeds normally.
- Stray writeComplete during a host read, and readComplete while IDLE → both are ignored. The host read still completes on its real readComplete.
- reset asserted in BUSY → memoryReadRequest drops immediately and no RespValid is issued. After release, the host is granted first.
